// File: rtl/ita_package.sv
// Shared types for the ITA output datapath: lane geometry, requantised output vector
// and the default depth/count type used by the activation output buffer.
package ita_package;

    localparam int N  = 4;
    localparam int WO = 8;

    typedef logic [N-1:0][WO-1:0] requant_oup_t;

    localparam int unsigned ACT_BUF_DEPTH = 8;

    typedef logic [$clog2(ACT_BUF_DEPTH):0] act_buf_cnt_t;

endpackage

// File: rtl/ita_act_buf_ram.sv
// Storage array for the activation output buffer: one synchronous write port,
// asynchronous read port, no reset on the data itself.
module ita_act_buf_ram
    import ita_package::*;
#(
    parameter int unsigned DEPTH = ACT_BUF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [AW-1:0] wr_addr,
    input  requant_oup_t wr_data,
    input  logic [AW-1:0] rd_addr,
    output requant_oup_t rd_data
);

    requant_oup_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ita_act_out_buffer.sv
// Output buffer behind the activation unit: FIFO with valid/ready egress, tile-row last tagging
// and early stall. Define ITA_ACT_BUF_STATS_EN to add sticky overflow flag and drop counter ports.
module ita_act_out_buffer
    import ita_package::*;
#(
    parameter int unsigned DEPTH   = ACT_BUF_DEPTH,
    parameter int unsigned ACT_LAT = 1,
    parameter int unsigned ROW_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  requant_oup_t             data_i,
    input  logic [ROW_W-1:0]         tile_rows_i,
    output logic                     stall_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output requant_oup_t             data_o,
    output logic                     last_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef ITA_ACT_BUF_STATS_EN
    ,
    output logic                     err_o,
    output logic [15:0]              drop_cnt_o
`endif
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    // Occupancy at which the remaining slots just cover the vectors still in flight.
    localparam int          STALL_AT = int'(DEPTH) - int'(ACT_LAT) - 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [ROW_W-1:0] row_cnt;
    logic [ROW_W-1:0] rows_eff;
    logic             stall_q;
    logic             stall_nxt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             overflow;
    logic             is_last_row;
    requant_oup_t     rd_data;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    assign valid_o  = ~empty;
    assign pop      = valid_o & ready_i;
    assign push     = valid_i & (~full | pop) & ~clear_i;
    assign overflow = valid_i & full & ~pop & ~clear_i;

    always_comb begin
        count_nxt = count_q;
        if (clear_i) begin
            count_nxt = '0;
        end else begin
            count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign stall_nxt = (int'(count_nxt) >= STALL_AT);

    assign rows_eff    = (tile_rows_i == '0) ? ROW_W'(1) : tile_rows_i;
    assign is_last_row = (row_cnt == rows_eff - ROW_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            row_cnt <= '0;
            stall_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            stall_q <= stall_nxt;
            if (clear_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                row_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    row_cnt <= is_last_row ? '0 : row_cnt + ROW_W'(1);
                end
            end
        end
    end

    ita_act_buf_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (data_i),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign data_o  = empty ? '0 : rd_data;
    assign last_o  = valid_o & is_last_row;
    assign count_o = count_q;
    assign stall_o = stall_q;

`ifdef ITA_ACT_BUF_STATS_EN
    logic        err_q;
    logic [15:0] drop_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else if (clear_i) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else if (overflow) begin
            err_q <= 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign err_o      = err_q;
    assign drop_cnt_o = drop_q;
`else
`ifndef SYNTHESIS
    // Without the stats ports a drop is invisible in hardware, so flag it in simulation.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !overflow)
        else $error("ita_act_out_buffer: vector dropped on overflow");
`endif
`endif

endmodule

// File: tb/tb_ita_act_out_buffer.sv
// Self-checking bench for ita_act_out_buffer against a queue-based reference model.
module tb_ita_act_out_buffer;
    import ita_package::*;

    localparam int DEPTH   = 8;
    localparam int ACT_LAT = 1;
    localparam int ROW_W   = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clear_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_i = 1'b0;
    requant_oup_t     data_i = '0;
    logic [ROW_W-1:0] tile_rows_i = 16;
    logic             stall_o;
    logic             valid_o;
    logic             last_o;
    requant_oup_t     data_o;
    logic [CW-1:0]    count_o;
`ifdef ITA_ACT_BUF_STATS_EN
    logic             err_o;
    logic [15:0]      drop_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    requant_oup_t q[$];
    int           m_row;
    bit           m_err;
    int           m_drop;

    always #5 clk_i = ~clk_i;

    ita_act_out_buffer #(
        .DEPTH   (DEPTH),
        .ACT_LAT (ACT_LAT),
        .ROW_W   (ROW_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .tile_rows_i (tile_rows_i),
        .stall_o     (stall_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .last_o      (last_o),
        .count_o     (count_o)
`ifdef ITA_ACT_BUF_STATS_EN
        ,
        .err_o       (err_o),
        .drop_cnt_o  (drop_cnt_o)
`endif
    );

    function automatic requant_oup_t rnd();
        requant_oup_t v;
        for (int i = 0; i < N; i++) v[i] = WO'($urandom);
        return v;
    endfunction

    function automatic int eff_rows();
        return (tile_rows_i == 0) ? 1 : int'(tile_rows_i);
    endfunction

    function automatic requant_oup_t exp_data();
        return (q.size() > 0) ? q[0] : '0;
    endfunction

    function automatic bit exp_last();
        return (q.size() > 0) && (m_row == eff_rows() - 1);
    endfunction

    function automatic bit exp_stall();
        return (DEPTH - q.size()) <= (ACT_LAT + 1);
    endfunction

    task automatic model_reset();
        q.delete();
        m_row  = 0;
        m_err  = 0;
        m_drop = 0;
    endtask

    // Advance the model by one cycle using the inputs currently applied, then clock the DUT.
    task automatic tick();
        bit pop;
        bit full;
        if (clear_i) begin
            model_reset();
        end else begin
            pop  = (q.size() > 0) && ready_i;
            full = (q.size() == DEPTH);
            if (pop) begin
                m_row = exp_last() ? 0 : m_row + 1;
                void'(q.pop_front());
            end
            if (valid_i && (!full || pop)) begin
                q.push_back(data_i);
            end else if (valid_i) begin
                m_err = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 0;
        ready_i = 0;
        clear_i = 0;
        data_i  = '0;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid cyc %0d got %b exp 0", i, valid_o); end
            checks++;
            if (data_o !== '0) begin errors++; $display("FAIL reset_data cyc %0d got %h exp 0", i, data_o); end
            checks++;
            if (count_o !== '0) begin errors++; $display("FAIL reset_count cyc %0d got %0d exp 0", i, count_o); end
            checks++;
            if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall cyc %0d got %b exp 0", i, stall_o); end
            checks++;
            if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last cyc %0d got %b exp 0", i, last_o); end
        end
`ifdef ITA_ACT_BUF_STATS_EN
        checks++;
        if (err_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
            errors++; $display("FAIL reset_stats got err %b drop %0d exp 0 0", err_o, drop_cnt_o);
        end
`endif
    endtask

    task automatic test_streaming();
        int n_last = 0;
        tile_rows_i = 16;
        ready_i = 1;
        for (int i = 0; i <= 64; i++) begin
            valid_i = (i < 64);
            data_i  = rnd();
            tick();
            checks++;
            if (valid_o !== (i < 64)) begin errors++; $display("FAIL stream_valid row %0d got %b exp %b", i, valid_o, (i < 64)); end
            checks++;
            if (data_o !== exp_data()) begin errors++; $display("FAIL stream_data row %0d got %h exp %h", i, data_o, exp_data()); end
            checks++;
            if (last_o !== exp_last()) begin errors++; $display("FAIL stream_last row %0d got %b exp %b", i, last_o, exp_last()); end
            if (i < 64) begin
                checks++;
                if (last_o !== ((i % 16) == 15)) begin errors++; $display("FAIL stream_last_pos row %0d got %b exp %b", i, last_o, ((i % 16) == 15)); end
                if (last_o === 1'b1) n_last++;
            end
        end
        checks++;
        if (n_last != 4) begin errors++; $display("FAIL stream_last_count got %0d exp 4", n_last); end
        checks++;
        if (count_o !== '0) begin errors++; $display("FAIL stream_end_count got %0d exp 0", count_o); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        int n;
        ready_i = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            valid_i = 1;
            data_i  = rnd();
            tick();
            checks++;
            if (count_o !== CW'(q.size())) begin errors++; $display("FAIL bp_count cyc %0d got %0d exp %0d", k, count_o, q.size()); end
            checks++;
            if (stall_o !== exp_stall()) begin errors++; $display("FAIL bp_stall cyc %0d got %b exp %b", k, stall_o, exp_stall()); end
            if (stall_o === 1'b1) begin
                seen = 1;
                checks++;
                if (count_o !== CW'(6)) begin errors++; $display("FAIL bp_stall_level got %0d exp 6", count_o); end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_stall_timeout got 0 exp 1"); end
        for (int k = 0; k < 2; k++) begin
            valid_i = 1;
            data_i  = rnd();
            tick();
        end
        valid_i = 0;
        checks++;
        if (count_o !== CW'(8)) begin errors++; $display("FAIL bp_full_count got %0d exp 8", count_o); end
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL bp_full_stall got %b exp 1", stall_o); end
        // Hold ready low a while: head must stay put.
        begin
            requant_oup_t held = data_o;
            tick();
            checks++;
            if (data_o !== held || valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold got %h/%b exp %h/1", data_o, valid_o, held); end
        end
        ready_i = 1;
        n = 0;
        while (q.size() > 0 && n < 12) begin
            tick();
            n++;
            checks++;
            if (data_o !== exp_data() || valid_o !== (q.size() > 0)) begin
                errors++; $display("FAIL bp_drain step %0d got %h/%b exp %h/%b", n, data_o, valid_o, exp_data(), (q.size() > 0));
            end
        end
        checks++;
        if (count_o !== '0 || stall_o !== 1'b0) begin errors++; $display("FAIL bp_drained got count %0d stall %b exp 0 0", count_o, stall_o); end
        idle_inputs();
    endtask

    task automatic test_full_pop();
        requant_oup_t fill[DEPTH];
        int n;
        ready_i = 0;
        for (int k = 0; k < DEPTH; k++) begin
            valid_i = 1;
            fill[k] = rnd();
            data_i  = fill[k];
            tick();
        end
        checks++;
        if (count_o !== CW'(DEPTH)) begin errors++; $display("FAIL fullpop_fill got %0d exp %0d", count_o, DEPTH); end
        valid_i = 1;
        ready_i = 1;
        data_i  = rnd();
        tick();
        checks++;
        if (count_o !== CW'(DEPTH)) begin errors++; $display("FAIL fullpop_count got %0d exp %0d", count_o, DEPTH); end
        checks++;
        if (data_o !== fill[1]) begin errors++; $display("FAIL fullpop_head got %h exp %h", data_o, fill[1]); end
`ifdef ITA_ACT_BUF_STATS_EN
        checks++;
        if (err_o !== 1'b0 || drop_cnt_o !== 16'd0) begin errors++; $display("FAIL fullpop_nodrop got %b %0d exp 0 0", err_o, drop_cnt_o); end
`endif
        valid_i = 0;
        n = 0;
        while (q.size() > 0 && n < 12) begin
            tick();
            n++;
            checks++;
            if (data_o !== exp_data()) begin errors++; $display("FAIL fullpop_drain step %0d got %h exp %h", n, data_o, exp_data()); end
        end
        checks++;
        if (q.size() != 0 || count_o !== '0) begin errors++; $display("FAIL fullpop_empty got %0d exp 0", count_o); end
        idle_inputs();
    endtask

`ifdef ITA_ACT_BUF_STATS_EN
    task automatic test_overflow();
        requant_oup_t fill[DEPTH];
        ready_i = 0;
        for (int k = 0; k < DEPTH; k++) begin
            valid_i = 1;
            fill[k] = rnd();
            data_i  = fill[k];
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            valid_i = 1;
            data_i  = rnd();
            tick();
        end
        valid_i = 0;
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", err_o); end
        checks++;
        if (drop_cnt_o !== 16'd3) begin errors++; $display("FAIL ovf_drop got %0d exp 3", drop_cnt_o); end
        checks++;
        if (count_o !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count got %0d exp %0d", count_o, DEPTH); end
        ready_i = 1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (data_o !== fill[k]) begin errors++; $display("FAIL ovf_contents idx %0d got %h exp %h", k, data_o, fill[k]); end
            tick();
        end
        checks++;
        if (err_o !== 1'b1 || drop_cnt_o !== 16'd3) begin errors++; $display("FAIL ovf_sticky got %b %0d exp 1 3", err_o, drop_cnt_o); end
        ready_i = 0;
        clear_i = 1;
        tick();
        clear_i = 0;
        checks++;
        if (err_o !== 1'b0 || drop_cnt_o !== 16'd0 || count_o !== '0) begin
            errors++; $display("FAIL ovf_clear got %b %0d %0d exp 0 0 0", err_o, drop_cnt_o, count_o);
        end
        idle_inputs();
    endtask
`endif

    task automatic test_clear_mid_tile();
        tile_rows_i = 16;
        ready_i = 0;
        for (int k = 0; k < 8; k++) begin
            valid_i = 1;
            data_i  = rnd();
            tick();
        end
        valid_i = 0;
        ready_i = 1;
        repeat (5) tick();
        ready_i = 0;
        checks++;
        if (count_o !== CW'(3)) begin errors++; $display("FAIL clr_pre_count got %0d exp 3", count_o); end
        clear_i = 1;
        valid_i = 1;
        ready_i = 1;
        data_i  = rnd();
        tick();
        clear_i = 0;
        valid_i = 0;
        checks++;
        if (count_o !== '0 || valid_o !== 1'b0 || data_o !== '0 || last_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL clr_state got cnt %0d v %b d %h l %b s %b exp 0", count_o, valid_o, data_o, last_o, stall_o);
        end
        ready_i = 1;
        for (int i = 0; i <= 16; i++) begin
            valid_i = (i < 16);
            data_i  = rnd();
            tick();
            if (i < 16) begin
                checks++;
                if (last_o !== (i == 15)) begin errors++; $display("FAIL clr_tile_last row %0d got %b exp %b", i, last_o, (i == 15)); end
                checks++;
                if (data_o !== exp_data()) begin errors++; $display("FAIL clr_tile_data row %0d got %h exp %h", i, data_o, exp_data()); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_zero_rows();
        tile_rows_i = 0;
        valid_i = 1;
        data_i  = rnd();
        tick();
        valid_i = 0;
        checks++;
        if (last_o !== 1'b1) begin errors++; $display("FAIL zero_rows_last got %b exp 1", last_o); end
        ready_i = 1;
        tick();
        idle_inputs();
        tile_rows_i = 16;
    endtask

    task automatic test_random();
        int opts[5] = '{0, 1, 3, 5, 16};
        bit pop;
        for (int c = 0; c < 400; c++) begin
            if (m_row == 0 && ($urandom % 8) == 0) tile_rows_i = ROW_W'(opts[$urandom % 5]);
            ready_i = ($urandom % 3) != 0;
            pop     = (q.size() > 0) && ready_i;
            valid_i = (($urandom % 4) != 0) && ((q.size() < DEPTH) || pop);
            clear_i = ($urandom % 64) == 0;
            data_i  = rnd();
            tick();
            checks++;
            if (valid_o !== (q.size() > 0) || data_o !== exp_data()) begin
                errors++; $display("FAIL rand_data cyc %0d got %b/%h exp %b/%h", c, valid_o, data_o, (q.size() > 0), exp_data());
            end
            checks++;
            if (last_o !== exp_last()) begin errors++; $display("FAIL rand_last cyc %0d got %b exp %b", c, last_o, exp_last()); end
            checks++;
            if (count_o !== CW'(q.size()) || stall_o !== exp_stall()) begin
                errors++; $display("FAIL rand_count cyc %0d got %0d/%b exp %0d/%b", c, count_o, stall_o, q.size(), exp_stall());
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            valid_i = 1;
            data_i  = rnd();
            tick();
        end
        idle_inputs();
        #2;
        rst_ni = 0;
        model_reset();
        #1;
        checks++;
        if (count_o !== '0 || valid_o !== 1'b0 || data_o !== '0 || stall_o !== 1'b0 || last_o !== 1'b0) begin
            errors++; $display("FAIL async_reset got cnt %0d v %b d %h s %b l %b exp 0", count_o, valid_o, data_o, stall_o, last_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        tick();
        checks++;
        if (count_o !== '0 || valid_o !== 1'b0) begin errors++; $display("FAIL async_reset_after got %0d/%b exp 0/0", count_o, valid_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pop();
`ifdef ITA_ACT_BUF_STATS_EN
        test_overflow();
`endif
        test_clear_mid_tile();
        test_zero_rows();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
